mac_psum_drain: RTL

MAC_PSUM_DRAIN -- requirements
Module: mac_psum_drain

---
 rtl/mac_psum_drain_if.sv | 25 ++
 rtl/mac_psum_drain.sv | 120 ++++++++++++
 2 files changed

// File: rtl/mac_psum_drain_if.sv
// Handshake bundle for the partial-sum drain: upstream MAC beats in,
// accumulated group results out.
interface mac_psum_drain_if #(
  parameter int DATA_W = 32,
  parameter int CNT_W  = 8
);
  logic              ivalid;
  logic              oready;
  logic [DATA_W-1:0] idata;
  logic [CNT_W-1:0]  icount;
  logic              ovalid;
  logic              iready;
  logic [DATA_W-1:0] result;
  logic              osat;

  modport master (
    output ivalid, idata, icount, iready,
    input  oready, ovalid, result, osat
  );

  modport slave (
    input  ivalid, idata, icount, iready,
    output oready, ovalid, result, osat
  );
endinterface

// File: rtl/mac_psum_drain.sv
// Accumulates groups of signed MAC partial sums with saturation and hands
// one result per group downstream; back-to-back groups run without a bubble.
module mac_psum_drain #(
  parameter int DATA_W = 32,
  parameter int CNT_W  = 8
) (
  input  logic             clock,
  input  logic             reset,
  mac_psum_drain_if.slave  bus
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCUM  = 2'd1,
    OUTPUT = 2'd2
  } state_t;

  localparam logic [DATA_W-1:0] SAT_MAX = {1'b0, {(DATA_W-1){1'b1}}};
  localparam logic [DATA_W-1:0] SAT_MIN = {1'b1, {(DATA_W-1){1'b0}}};

  state_t            r_state;
  state_t            w_state_next;
  logic [DATA_W-1:0] r_acc;
  logic [DATA_W-1:0] w_acc_next;
  logic              r_sat;
  logic              w_sat_next;
  logic [CNT_W-1:0]  r_remaining;
  logic [CNT_W-1:0]  w_remaining_next;

  logic              w_oready;
  logic              w_ovalid;
  logic              w_up_fire;
  logic              w_dn_fire;
  logic [DATA_W:0]   w_sum;
  logic              w_ovf;
  logic [DATA_W-1:0] w_clamped;
  logic              w_first_single;
  logic [CNT_W-1:0]  w_first_remaining;

  // Gated by reset so nothing leaks out while a pending group is being discarded.
  assign w_oready  = !reset && ((r_state == OUTPUT) ? bus.iready : 1'b1);
  assign w_ovalid  = !reset && (r_state == OUTPUT);
  assign w_up_fire = bus.ivalid && w_oready;
  assign w_dn_fire = w_ovalid && bus.iready;

  assign bus.oready = w_oready;
  assign bus.ovalid = w_ovalid;
  assign bus.result = reset ? '0 : r_acc;
  assign bus.osat   = !reset && r_sat;

  // One guard bit is enough: overflow shows as the two top bits disagreeing.
  assign w_sum     = {r_acc[DATA_W-1], r_acc} + {bus.idata[DATA_W-1], bus.idata};
  assign w_ovf     = w_sum[DATA_W] ^ w_sum[DATA_W-1];
  assign w_clamped = w_ovf ? (w_sum[DATA_W] ? SAT_MIN : SAT_MAX) : w_sum[DATA_W-1:0];

  // A zero group length behaves as a single-beat group.
  assign w_first_single    = (bus.icount <= CNT_W'(1));
  assign w_first_remaining = w_first_single ? '0 : (bus.icount - CNT_W'(1));

  always_comb begin
    w_state_next     = r_state;
    w_acc_next       = r_acc;
    w_sat_next       = r_sat;
    w_remaining_next = r_remaining;

    case (r_state)
      IDLE: begin
        if (w_up_fire) begin
          w_acc_next       = bus.idata;
          w_sat_next       = 1'b0;
          w_remaining_next = w_first_remaining;
          w_state_next     = w_first_single ? OUTPUT : ACCUM;
        end
      end

      ACCUM: begin
        if (w_up_fire) begin
          w_acc_next       = w_clamped;
          w_sat_next       = r_sat | w_ovf;
          w_remaining_next = r_remaining - CNT_W'(1);
          if (r_remaining == CNT_W'(1)) begin
            w_state_next = OUTPUT;
          end
        end
      end

      OUTPUT: begin
        if (w_dn_fire) begin
          if (w_up_fire) begin
            w_acc_next       = bus.idata;
            w_sat_next       = 1'b0;
            w_remaining_next = w_first_remaining;
            w_state_next     = w_first_single ? OUTPUT : ACCUM;
          end else begin
            w_state_next = IDLE;
          end
        end
      end

      default: begin
        w_state_next = IDLE;
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state     <= IDLE;
      r_acc       <= '0;
      r_sat       <= 1'b0;
      r_remaining <= '0;
    end else begin
      r_state     <= w_state_next;
      r_acc       <= w_acc_next;
      r_sat       <= w_sat_next;
      r_remaining <= w_remaining_next;
    end
  end

endmodule
